// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-port and response signals between the lab front end, the issuer and the ALU.
// The master modport is the issuer's view; the slave modport is the surrounding environment.
interface alu_cmd_issuer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [2:0]       alu_fun_sel;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_res;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_res, alu_cout, alu_overflow,
        input  rsp_ready,
        output cmd_ready,
        output alu_fun_sel, alu_in_a, alu_in_b,
        output rsp_valid, rsp_res, rsp_cout, rsp_ovf
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_res, alu_cout, alu_overflow,
        output rsp_ready,
        input  cmd_ready,
        input  alu_fun_sel, alu_in_a, alu_in_b,
        input  rsp_valid, rsp_res, rsp_cout, rsp_ovf
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to a combinational ALU from registered ports, captures the
// result a cycle later and holds it on a valid/ready response channel.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_issuer_if.master    bus,
    output logic [CNT_W-1:0]    op_count,
    output logic [CNT_W-1:0]    ovf_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             state_q, state_d;
    logic [2:0]         fun_sel_q, fun_sel_d;
    logic [WIDTH-1:0]   in_a_q, in_a_d;
    logic [WIDTH-1:0]   in_b_q, in_b_d;
    logic [WIDTH-1:0]   rsp_res_q, rsp_res_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    logic               cmd_ready;
    logic               rsp_valid;
    logic               negate_b;
    logic [WIDTH-1:0]   eff_b;

    // The ALU adds in_a+in_b for SUB and SLT, so B is handed over already negated.
    assign negate_b = (bus.cmd_op == 3'd1) || (bus.cmd_op == 3'd6);
    assign eff_b    = negate_b ? (~bus.cmd_b + WIDTH'(1)) : bus.cmd_b;

    always_comb begin
        state_d     = state_q;
        fun_sel_d   = fun_sel_q;
        in_a_d      = in_a_q;
        in_b_d      = in_b_q;
        rsp_res_d   = rsp_res_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        op_count_d  = op_count_q;
        ovf_count_d = ovf_count_q;
        cmd_ready   = (state_q == StIdle) && !rst;
        rsp_valid   = (state_q == StResp) && !rst;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready) begin
                    fun_sel_d = bus.cmd_op;
                    in_a_d    = bus.cmd_a;
                    in_b_d    = eff_b;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                rsp_res_d  = bus.alu_res;
                rsp_cout_d = bus.alu_cout;
                rsp_ovf_d  = bus.alu_overflow;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_valid && bus.rsp_ready) begin
                    if (op_count_q != {CNT_W{1'b1}}) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    if (rsp_ovf_q && (ovf_count_q != {CNT_W{1'b1}})) begin
                        ovf_count_d = ovf_count_q + CNT_W'(1);
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fun_sel_q   <= '0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            rsp_res_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fun_sel_q   <= fun_sel_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            rsp_res_q   <= rsp_res_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
            op_count_q  <= op_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.alu_fun_sel = fun_sel_q;
    assign bus.alu_in_a    = in_a_q;
    assign bus.alu_in_b    = in_b_q;
    assign bus.rsp_res     = rsp_res_q;
    assign bus.rsp_cout    = rsp_cout_q;
    assign bus.rsp_ovf     = rsp_ovf_q;
    assign op_count        = op_count_q;
    assign ovf_count       = ovf_count_q;

endmodule
